// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if -- handshake bundle for the round-robin arbitrating mux.
//
// Purpose: groups the per-channel request side and the single registered
// output side into one interface so the arbiter and its environment share
// one definition of widths and directions.
//
// Parameters:
//   WIDTH   data width per channel
//   NUM_IN  number of input channels
//   SEL_W   width of the channel index
//
// Signals:
//   in_data   packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  per-channel request
//   in_ready  per-channel accept (one-hot or zero)
//   out_data  registered selected data
//   out_valid out_data holds an undelivered beat
//   out_ready downstream accept
//   out_sel   index of the channel that supplied out_data
//   lock      hold grant on current channel (only with RR_MUX_LOCK_EN)
//
// Modports: slave = arbiter view, master = environment view.
// Optional feature macro: RR_MUX_LOCK_EN adds the lock signal.

interface rr_arb_mux_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_sel;
`ifdef RR_MUX_LOCK_EN
    logic                    lock;

    modport slave  (input  in_data, in_valid, out_ready, lock,
                    output in_ready, out_data, out_valid, out_sel);
    modport master (output in_data, in_valid, out_ready, lock,
                    input  in_ready, out_data, out_valid, out_sel);
`else
    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid, out_sel);
    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid, out_sel);
`endif
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux -- round-robin arbiter feeding a single registered output slot.
//
// Purpose: picks one requesting channel per cycle, starting the search at
// the channel after the last winner, and registers its data into a one-deep
// output buffer (EMPTY/FULL). Sustains one beat per cycle when downstream
// is always ready; holds the beat stable under backpressure.
//
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high
//   bus    rr_arb_mux_if.slave (in_data/in_valid/in_ready,
//          out_data/out_valid/out_ready/out_sel, optional lock)
//
// Parameters: WIDTH (data width), NUM_IN (2..16 channels),
//             SEL_W (channel index width, derived).
// Optional feature macro: RR_MUX_LOCK_EN -- a transfer with lock=1 pins the
// grant to that channel until a transfer from it with lock=0.

module rr_arb_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input logic           clk,
    input logic           reset,
    rr_arb_mux_if.slave   bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  grant;
    logic [SEL_W-1:0]  next_ptr;
    logic              any_req;
    logic              load_en;
    logic              transfer;
    logic [NUM_IN-1:0] ready_vec;
    logic [SEL_W:0]    cand;
    logic [SEL_W-1:0]  cand_idx;
`ifdef RR_MUX_LOCK_EN
    logic              lock_active;
    logic [SEL_W-1:0]  lock_ch;
`endif

    assign load_en  = (state_q == EMPTY) || bus.out_ready;
    assign transfer = |ready_vec;
    assign next_ptr = (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + 1'b1;

    // Circular search from rr_ptr. The candidate carries one extra bit so
    // the wrap is a single conditional subtract, which also keeps a
    // non-power-of-two channel count from ever producing an index >= NUM_IN.
    always_comb begin
        any_req  = 1'b0;
        grant    = rr_ptr;
        cand     = '0;
        cand_idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            cand = {1'b0, rr_ptr} + (SEL_W+1)'(i);
            if (cand >= (SEL_W+1)'(NUM_IN))
                cand = cand - (SEL_W+1)'(NUM_IN);
            cand_idx = cand[SEL_W-1:0];
            if (!any_req && bus.in_valid[cand_idx]) begin
                any_req = 1'b1;
                grant   = cand_idx;
            end
        end
`ifdef RR_MUX_LOCK_EN
        // A held lock overrides the rotation; other channels simply wait.
        if (lock_active) begin
            any_req = bus.in_valid[lock_ch];
            grant   = lock_ch;
        end
`endif
    end

    // Reset gates the accept so nothing is consumed during a reset cycle.
    always_comb begin
        ready_vec = '0;
        if (!reset && load_en && any_req)
            ready_vec[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    // A new transfer always fills the slot; otherwise a delivery drains it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (transfer) state_d = FULL;
            FULL:  if (bus.out_ready && !transfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output slot and pointer. Data and select keep their last values when
    // the slot drains, since only a transfer writes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            sel_q  <= '0;
            rr_ptr <= '0;
`ifdef RR_MUX_LOCK_EN
            lock_active <= 1'b0;
            lock_ch     <= '0;
`endif
        end else if (transfer) begin
            data_q <= bus.in_data[grant*WIDTH +: WIDTH];
            sel_q  <= grant;
`ifdef RR_MUX_LOCK_EN
            if (bus.lock) begin
                lock_active <= 1'b1;
                lock_ch     <= grant;
            end else begin
                lock_active <= 1'b0;
                rr_ptr      <= next_ptr;
            end
`else
            rr_ptr <= next_ptr;
`endif
        end
    end

    assign bus.in_ready  = ready_vec;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = (state_q == FULL);

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux -- directed, table-driven bench for rr_arb_mux.
//
// Drives a 4-channel instance through a vector table (reset, fairness,
// drain, backpressure, mid-operation reset) and a 3-channel instance
// through a wrap sequence. With RR_MUX_LOCK_EN defined, a lock sequence
// is also exercised on the 4-channel instance.

module tb_rr_arb_mux;
    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_0001;
    localparam logic [31:0] D2 = 32'hDEAD_BEEF;
    localparam logic [31:0] D3 = 32'h4444_0003;
    localparam logic [31:0] E0 = 32'hA0A0_0000;
    localparam logic [31:0] E1 = 32'hA1A1_0001;
    localparam logic [31:0] E2 = 32'hA2A2_0002;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    rr_arb_mux_if #(.WIDTH(32), .NUM_IN(4)) bus4 ();
    rr_arb_mux_if #(.WIDTH(32), .NUM_IN(3)) bus3 ();

    rr_arb_mux #(.WIDTH(32), .NUM_IN(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    rr_arb_mux #(.WIDTH(32), .NUM_IN(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic        ordy;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [1:0]  exp_sel;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[22];

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset          = v.rst;
        bus4.in_valid  = v.valid;
        bus4.out_ready = v.ordy;
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] v,
                                input logic o, input logic [3:0] er,
                                input logic ev, input logic [1:0] es,
                                input logic [31:0] ed);
        vec_t t;
        t.rst = r; t.valid = v; t.ordy = o; t.exp_ready = er;
        t.exp_valid = ev; t.exp_sel = es; t.exp_data = ed;
        return t;
    endfunction

    initial begin
        logic [2:0] w_valid [8];
        logic [2:0] w_ready [8];
        logic [1:0] w_sel   [8];
        logic [31:0] w_data [8];
`ifdef RR_MUX_LOCK_EN
        logic       l_lock  [4];
        logic [3:0] l_ready [4];
        logic [1:0] l_sel   [4];
        logic [31:0] l_data [4];
`endif
        tests = 0;
        fails = 0;

        // reset, then idle
        vecs[0]  = mk(1, 4'b0000, 0, 4'b0000, 0, 2'd0, 32'h0);
        vecs[1]  = mk(1, 4'b0000, 0, 4'b0000, 0, 2'd0, 32'h0);
        vecs[2]  = mk(0, 4'b0000, 1, 4'b0000, 0, 2'd0, 32'h0);
        // fairness: all request, 0,1,2,3,0
        vecs[3]  = mk(0, 4'b1111, 1, 4'b0001, 1, 2'd0, D0);
        vecs[4]  = mk(0, 4'b1111, 1, 4'b0010, 1, 2'd1, D1);
        vecs[5]  = mk(0, 4'b1111, 1, 4'b0100, 1, 2'd2, D2);
        vecs[6]  = mk(0, 4'b1111, 1, 4'b1000, 1, 2'd3, D3);
        vecs[7]  = mk(0, 4'b1111, 1, 4'b0001, 1, 2'd0, D0);
        // drain keeps last data/sel
        vecs[8]  = mk(0, 4'b0000, 1, 4'b0000, 0, 2'd0, D0);
        // backpressure on a channel-2 beat for 5 cycles, then release
        vecs[9]  = mk(0, 4'b0100, 0, 4'b0100, 1, 2'd2, D2);
        vecs[10] = mk(0, 4'b1111, 0, 4'b0000, 1, 2'd2, D2);
        vecs[11] = mk(0, 4'b1111, 0, 4'b0000, 1, 2'd2, D2);
        vecs[12] = mk(0, 4'b1111, 0, 4'b0000, 1, 2'd2, D2);
        vecs[13] = mk(0, 4'b1111, 0, 4'b0000, 1, 2'd2, D2);
        vecs[14] = mk(0, 4'b1111, 0, 4'b0000, 1, 2'd2, D2);
        vecs[15] = mk(0, 4'b0000, 1, 4'b0000, 0, 2'd2, D2);
        // pointer at 3: wrap search to channel 0, then channel 1
        vecs[16] = mk(0, 4'b0011, 1, 4'b0001, 1, 2'd0, D0);
        vecs[17] = mk(0, 4'b0011, 1, 4'b0010, 1, 2'd1, D1);
        vecs[18] = mk(0, 4'b0001, 0, 4'b0000, 1, 2'd1, D1);
        // reset drops the held beat; next grant from channel 0
        vecs[19] = mk(1, 4'b0001, 0, 4'b0000, 0, 2'd0, 32'h0);
        vecs[20] = mk(0, 4'b1111, 1, 4'b0001, 1, 2'd0, D0);
        vecs[21] = mk(0, 4'b0000, 1, 4'b0000, 0, 2'd0, D0);

        // 3-channel wrap: 101 gives 0,2,0,2; then 110 gives 1,2; then 011 gives 0
        w_valid = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b110, 3'b110, 3'b011, 3'b000};
        w_ready = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b010, 3'b100, 3'b001, 3'b000};
        w_sel   = '{2'd0,   2'd2,   2'd0,   2'd2,   2'd1,   2'd2,   2'd0,   2'd0};
        w_data  = '{E0,     E2,     E0,     E2,     E1,     E2,     E0,     E0};

        reset          = 1'b1;
        bus4.in_data   = {D3, D2, D1, D0};
        bus4.in_valid  = '0;
        bus4.out_ready = 1'b0;
        bus3.in_data   = {E2, E1, E0};
        bus3.in_valid  = '0;
        bus3.out_ready = 1'b1;
`ifdef RR_MUX_LOCK_EN
        bus4.lock = 1'b0;
        bus3.lock = 1'b0;
`endif

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #2;
            checkOutput($sformatf("v%0d in_ready", i), 32'(bus4.in_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d out_valid", i), 32'(bus4.out_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("v%0d out_sel", i), 32'(bus4.out_sel), 32'(vecs[i].exp_sel));
            checkOutput($sformatf("v%0d out_data", i), bus4.out_data, vecs[i].exp_data);
        end

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            reset         = 1'b0;
            bus4.in_valid = '0;
            bus3.in_valid = w_valid[i];
            #2;
            checkOutput($sformatf("wrap%0d in_ready", i), 32'(bus3.in_ready), 32'(w_ready[i]));
            @(posedge clk);
            #1;
            checkOutput($sformatf("wrap%0d out_sel", i), 32'(bus3.out_sel), 32'(w_sel[i]));
            checkOutput($sformatf("wrap%0d out_data", i), bus3.out_data, w_data[i]);
            checkOutput($sformatf("wrap%0d out_valid", i), 32'(bus3.out_valid), 32'(w_valid[i] != 3'b000));
        end

`ifdef RR_MUX_LOCK_EN
        // channel 1 sends lock=1,1,0 while channel 2 also requests
        l_lock  = '{1'b1, 1'b1, 1'b0, 1'b0};
        l_ready = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
        l_sel   = '{2'd1, 2'd1, 2'd1, 2'd2};
        l_data  = '{D1, D1, D1, D2};
        @(negedge clk);
        reset         = 1'b1;
        bus3.in_valid = '0;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            reset          = 1'b0;
            bus4.in_valid  = 4'b0110;
            bus4.out_ready = 1'b1;
            bus4.lock      = l_lock[i];
            #2;
            checkOutput($sformatf("lock%0d in_ready", i), 32'(bus4.in_ready), 32'(l_ready[i]));
            @(posedge clk);
            #1;
            checkOutput($sformatf("lock%0d out_sel", i), 32'(bus4.out_sel), 32'(l_sel[i]));
            checkOutput($sformatf("lock%0d out_data", i), bus4.out_data, l_data[i]);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, data width per channel.
REQ-002 The module SHALL have parameter NUM_IN, default 4, number of input channels, legal range 2..16, power of two not required.
REQ-003 The module SHALL have derived parameter SEL_W, default $clog2(NUM_IN), width of the channel index.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  NUM_IN*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NUM_IN  per-channel request.
REQ-008 in_ready  output  NUM_IN  per-channel accept; a beat transfers on channel i when in_valid[i] & in_ready[i].
REQ-009 out_data  output  WIDTH  registered selected data.
REQ-010 out_valid  output  1  out_data holds an undelivered beat.
REQ-011 out_ready  input  1  downstream accept; beat delivered when out_valid & out_ready.
REQ-012 out_sel  output  SEL_W  index of the channel that supplied out_data.
REQ-013 lock  input  1  present only with RR_MUX_LOCK_EN; hold grant on current channel.

Function
REQ-014 The block SHALL hold one output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 load_en SHALL equal !out_valid | out_ready, combinationally.
REQ-016 The grant SHALL be the first channel with in_valid set, searching from rr_ptr upward, wrapping from NUM_IN-1 to 0.
REQ-017 in_ready SHALL be one-hot on the granted channel when load_en=1 and any in_valid is set, else all zero; in_ready SHALL never have more than one bit set.
REQ-018 On a transfer, out_data, out_sel and out_valid=1 SHALL update at the next edge; latency input-to-output is exactly 1 cycle.
REQ-019 After a transfer from channel g, rr_ptr SHALL become g+1, wrapping to 0 when g=NUM_IN-1, including non-power-of-two NUM_IN.
REQ-020 While FULL and out_ready=0, out_data, out_sel and out_valid SHALL remain stable and all in_ready SHALL be 0.
REQ-021 Simultaneous delivery and new transfer in one cycle SHALL keep FULL with new data, sustaining one beat per cycle.
REQ-022 Delivery with no in_valid set SHALL go FULL->EMPTY; out_data and out_sel SHALL keep their last values.
REQ-023 With no requests, rr_ptr SHALL not change.
REQ-024 in_ready SHALL not depend on in_data; no combinational path from in_data to any output.

Reset
REQ-025 With reset high at an edge, out_valid=0, out_data=0, out_sel=0, rr_ptr=0, lock state cleared.
REQ-026 in_ready SHALL be all zero in any cycle in which reset is high.
REQ-027 Reset mid-operation SHALL discard a held undelivered beat without delivery.

Configuration
REQ-028 Macro RR_MUX_LOCK_EN SHALL compile in the lock port and grant-hold logic.
REQ-029 With RR_MUX_LOCK_EN, a transfer with lock=1 SHALL set lock state on that channel; while set, only that channel SHALL be granted; other requests wait.
REQ-030 With RR_MUX_LOCK_EN, a transfer with lock=0 SHALL clear lock state and advance rr_ptr per REQ-019; rr_ptr SHALL not advance while locked.
REQ-031 Without RR_MUX_LOCK_EN, the lock port and lock state SHALL be absent and arbitration pure round-robin.

Verification
REQ-032 Reset then idle: reset high 2 cycles -> out_valid=0, out_data=0, out_sel=0, in_ready=4'b0000.
REQ-033 Fairness: NUM_IN=4, in_valid=4'b1111, out_ready=1 continuously -> out_sel sequence 0,1,2,3,0, one beat per cycle, data matching channel.
REQ-034 Backpressure: FULL with out_sel=2, data 32'hDEAD_BEEF, out_ready=0 for 5 cycles -> output stable, in_ready=0; release -> delivered once.
REQ-035 Wrap with NUM_IN=3: in_valid=3'b101, rr_ptr=0 -> grants 0,2,0,2; rr_ptr never 3.
REQ-036 Reset mid-operation: FULL beat pending, reset pulse 1 cycle -> out_valid=0 next cycle, beat never delivered, next grant from channel 0.
REQ-037 Lock (RR_MUX_LOCK_EN): channel 1 sends 3 beats lock=1,1,0 while channel 2 requests -> out_sel 1,1,1,2.
